fizzbuzz_line_gen: RTL

//   Converts the slow frame-rate counter value into the 8-character FizzBuzz text line that the

---
 rtl/fizzbuzz_line_gen_if.sv | 21 ++
 rtl/fizzbuzz_line_gen.sv | 138 +++++++++++++
 2 files changed

// File: rtl/fizzbuzz_line_gen_if.sv
// rtl/fizzbuzz_line_gen_if.sv - value capture / line commit bus between frame counter, generator and renderer
interface fizzbuzz_line_gen_if #(
    parameter int VALUE_W = 6
);
    logic               newframe;
    logic [VALUE_W-1:0] value_in;
    logic               value_valid;
    logic               busy;
    logic [31:0]        line;
    logic               line_valid;

    modport master (
        output newframe, value_in, value_valid,
        input  busy, line, line_valid
    );

    modport slave (
        input  newframe, value_in, value_valid,
        output busy, line, line_valid
    );
endinterface

// File: rtl/fizzbuzz_line_gen.sv
// rtl/fizzbuzz_line_gen.sv - serial BCD + mod-3/mod-5 FizzBuzz line generator, frame-synchronous commit
module fizzbuzz_line_gen #(
    parameter int VALUE_W    = 6,
    parameter int BCD_DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    fizzbuzz_line_gen_if.slave  bus
);
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int BCD_W = 4 * BCD_DIGITS;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CONV    = 2'd1;
    localparam logic [1:0] COMPOSE = 2'd2;
    localparam logic [1:0] PEND    = 2'd3;

    localparam logic [31:0] LINE_FIZZBUZZ = 32'hEEDA_EECB;
    localparam logic [31:0] LINE_FIZZ     = 32'hFFFF_EECB;
    localparam logic [31:0] LINE_BUZZ     = 32'hFFFF_EEDA;

    logic [1:0]         state;
    logic [VALUE_W-1:0] shreg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd;
    logic [1:0]         r3;
    logic [2:0]         r5;
    logic [31:0]        next_line;
    logic [31:0]        line_q;
    logic               line_valid_q;

    logic               bit_in;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [2:0]         t3;
    logic [2:0]         t3_red;
    logic [3:0]         t5;
    logic [3:0]         t5_red;
    logic [31:0]        digit_line;
    logic [31:0]        composed;

    assign bit_in = shreg[VALUE_W-1];

    // One double-dabble step: correct digits >= 5 before the shift so they carry as decimal.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[BCD_W-2:0], bit_in};
    end

    // Remainders stay below the modulus, so a single conditional subtract suffices.
    always_comb begin
        t3     = {r3, bit_in};
        t3_red = (t3 >= 3'd3) ? t3 - 3'd3 : t3;
        t5     = {r5, bit_in};
        t5_red = (t5 >= 4'd5) ? t5 - 4'd5 : t5;
    end

    // Walk digits from most significant, packing from the leftmost char once a nonzero is seen.
    always_comb begin
        int   pos;
        logic started;
        pos        = 0;
        started    = 1'b0;
        digit_line = '1;
        for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
            if (started || (bcd[i*4 +: 4] != 4'd0)) begin
                started                  = 1'b1;
                digit_line[pos*4 +: 4]   = bcd[i*4 +: 4];
                pos                      = pos + 1;
            end
        end
        if (r3 == 2'd0 && r5 == 3'd0)
            composed = LINE_FIZZBUZZ;
        else if (r3 == 2'd0)
            composed = LINE_FIZZ;
        else if (r5 == 3'd0)
            composed = LINE_BUZZ;
        else
            composed = digit_line;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            bcd          <= '0;
            r3           <= '0;
            r5           <= '0;
            next_line    <= '0;
            line_q       <= 32'hFFFF_FFFF;
            line_valid_q <= 1'b0;
        end else begin
            line_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.value_valid) begin
                        shreg <= bus.value_in;
                        cnt   <= '0;
                        bcd   <= '0;
                        r3    <= '0;
                        r5    <= '0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    shreg <= {shreg[VALUE_W-2:0], 1'b0};
                    bcd   <= bcd_shift;
                    r3    <= t3_red[1:0];
                    r5    <= t5_red[2:0];
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(VALUE_W - 1))
                        state <= COMPOSE;
                end
                COMPOSE: begin
                    next_line <= composed;
                    state     <= PEND;
                end
                PEND: begin
                    if (bus.newframe) begin
                        line_q       <= next_line;
                        line_valid_q <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.line       = line_q;
    assign bus.line_valid = line_valid_q;
endmodule
